// File: rtl/safe_lock_ctrl_if.sv
// User/comparator side of the safe lock controller: entry strobe, comparator
// status, relock and alarm-clear requests in; lock status and failure count out.
interface safe_lock_ctrl_if;
    logic       enter;
    logic [1:0] status_in;
    logic       close;
    logic       clear_alarm;
    logic       unlocked;
    logic       penalty;
    logic       alarm;
    logic [3:0] fail_cnt;

    modport master (
        output enter, status_in, close, clear_alarm,
        input  unlocked, penalty, alarm, fail_cnt
    );

    modport slave (
        input  enter, status_in, close, clear_alarm,
        output unlocked, penalty, alarm, fail_cnt
    );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Lock controller behind the code comparator: timed open window, retry penalty
// after each wrong code, and a latched alarm after MAX_TRIES consecutive failures.
module safe_lock_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int OPEN_CYCLES    = 16,
    parameter int PENALTY_CYCLES = 32
) (
    input logic           clk,
    input logic           rst_n,
    safe_lock_ctrl_if.slave bus
);

    localparam int TIMER_MAX = (OPEN_CYCLES > PENALTY_CYCLES) ? OPEN_CYCLES : PENALTY_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] PENALTY_LOAD = TIMER_W'(PENALTY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_STEP   = TIMER_W'(1);
    localparam logic [3:0]         MAX_CNT      = 4'(MAX_TRIES);
    localparam logic [1:0]         ST_MATCH     = 2'b10;

    typedef enum logic [1:0] {
        LOCKED,
        OPEN,
        PENALTY,
        ALARM
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         fail_cnt;
    logic               unlocked;
    logic               penalty;
    logic               alarm;
    logic [3:0]         fail_inc;
    logic               timer_done;

    // Saturating increment: the count can never wrap past MAX_TRIES.
    assign fail_inc   = (fail_cnt >= MAX_CNT) ? MAX_CNT : fail_cnt + 4'd1;
    assign timer_done = (timer == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            timer    <= '0;
            fail_cnt <= '0;
            unlocked <= 1'b0;
            penalty  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            unique case (state)
                LOCKED: begin
                    if (bus.enter) begin
                        if (bus.status_in == ST_MATCH) begin
                            state    <= OPEN;
                            unlocked <= 1'b1;
                            fail_cnt <= '0;
                            timer    <= OPEN_LOAD;
                        end else begin
                            // Invalid status codes are treated as a wrong code.
                            fail_cnt <= fail_inc;
                            if (fail_inc == MAX_CNT) begin
                                state <= ALARM;
                                alarm <= 1'b1;
                            end else begin
                                state   <= PENALTY;
                                penalty <= 1'b1;
                                timer   <= PENALTY_LOAD;
                            end
                        end
                    end
                end

                OPEN: begin
                    if (timer_done || bus.close) begin
                        state    <= LOCKED;
                        unlocked <= 1'b0;
                        timer    <= '0;
                    end else begin
                        timer <= timer - TIMER_STEP;
                    end
                end

                PENALTY: begin
                    // Entries during the penalty are dropped, not queued.
                    if (timer_done) begin
                        state   <= LOCKED;
                        penalty <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_STEP;
                    end
                end

                ALARM: begin
                    if (bus.clear_alarm) begin
                        state    <= LOCKED;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                    end
                end

                default: begin
                    state    <= LOCKED;
                    timer    <= '0;
                    unlocked <= 1'b0;
                    penalty  <= 1'b0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unlocked = unlocked;
    assign bus.penalty  = penalty;
    assign bus.alarm    = alarm;
    assign bus.fail_cnt = fail_cnt;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl with default parameters (3 tries, 16 open, 32 penalty).
module tb_safe_lock_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    safe_lock_ctrl_if bus ();

    safe_lock_ctrl #(
        .MAX_TRIES      (3),
        .OPEN_CYCLES    (16),
        .PENALTY_CYCLES (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Compares {unlocked, penalty, alarm, fail_cnt} against the expected values.
    task automatic chk(input string tag, input logic u, input logic p, input logic a,
                       input logic [3:0] fc);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {bus.unlocked, bus.penalty, bus.alarm, bus.fail_cnt};
        exp = {u, p, a, fc};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed u/p/a/fc=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                   tag, obs[6], obs[5], obs[4], obs[3:0], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic do_enter(input logic [1:0] st);
        bus.enter     = 1'b1;
        bus.status_in = st;
        tick();
        bus.enter     = 1'b0;
        bus.status_in = 2'b00;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.enter       = 1'b0;
        bus.status_in   = 2'b00;
        bus.close       = 1'b0;
        bus.clear_alarm = 1'b0;

        ticks(3);
        chk("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_locked", 1'b0, 1'b0, 1'b0, 4'd0);

        // Correct code: open for exactly 16 cycles.
        do_enter(2'b10);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("open_c%0d", i), 1'b1, 1'b0, 1'b0, 4'd0);
            tick();
        end
        chk("open_expired", 1'b0, 1'b0, 1'b0, 4'd0);

        // Relock with close on the 5th unlocked cycle.
        do_enter(2'b10);
        ticks(4);
        chk("open_5th", 1'b1, 1'b0, 1'b0, 4'd0);
        bus.close = 1'b1;
        tick();
        bus.close = 1'b0;
        chk("close_relock", 1'b0, 1'b0, 1'b0, 4'd0);

        // Wrong code: 32-cycle penalty; a correct entry inside it is dropped.
        do_enter(2'b01);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                chk("pen_before_drop", 1'b0, 1'b1, 1'b0, 4'd1);
                do_enter(2'b10);
                chk("pen_enter_dropped", 1'b0, 1'b1, 1'b0, 4'd1);
            end else begin
                if (i == 0 || i == 31) chk($sformatf("pen_c%0d", i), 1'b0, 1'b1, 1'b0, 4'd1);
                tick();
            end
        end
        chk("pen_expired", 1'b0, 1'b0, 1'b0, 4'd1);

        // Success clears the count.
        do_enter(2'b10);
        chk("success_clears", 1'b1, 1'b0, 1'b0, 4'd0);
        bus.close = 1'b1;
        tick();
        bus.close = 1'b0;

        // Three failures (01, invalid 00, invalid 11) -> alarm, no third penalty.
        do_enter(2'b01);
        chk("fail1", 1'b0, 1'b1, 1'b0, 4'd1);
        ticks(32);
        chk("fail1_done", 1'b0, 1'b0, 1'b0, 4'd1);
        do_enter(2'b00);
        chk("fail2_invalid", 1'b0, 1'b1, 1'b0, 4'd2);
        ticks(32);
        do_enter(2'b11);
        chk("fail3_alarm", 1'b0, 1'b0, 1'b1, 4'd3);
        do_enter(2'b10);
        bus.close = 1'b1;
        tick();
        bus.close = 1'b0;
        do_enter(2'b01);
        chk("alarm_holds", 1'b0, 1'b0, 1'b1, 4'd3);
        ticks(40);
        chk("alarm_latched", 1'b0, 1'b0, 1'b1, 4'd3);
        bus.clear_alarm = 1'b1;
        tick();
        bus.clear_alarm = 1'b0;
        chk("alarm_cleared", 1'b0, 1'b0, 1'b0, 4'd0);

        // Two failures, clear_alarm ignored in LOCKED, success, then one failure.
        do_enter(2'b01);
        ticks(32);
        do_enter(2'b01);
        ticks(32);
        chk("two_fails", 1'b0, 1'b0, 1'b0, 4'd2);
        bus.clear_alarm = 1'b1;
        tick();
        bus.clear_alarm = 1'b0;
        chk("clear_outside_alarm", 1'b0, 1'b0, 1'b0, 4'd2);
        do_enter(2'b10);
        chk("success_after_two", 1'b1, 1'b0, 1'b0, 4'd0);
        bus.close = 1'b1;
        tick();
        bus.close = 1'b0;
        do_enter(2'b01);
        chk("single_fail_no_alarm", 1'b0, 1'b1, 1'b0, 4'd1);
        ticks(32);

        // Asynchronous reset in the 7th open cycle.
        do_enter(2'b10);
        ticks(6);
        chk("open_c7", 1'b1, 1'b0, 1'b0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_open", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_enter(2'b01);
        chk("after_rst_open_fail", 1'b0, 1'b1, 1'b0, 4'd1);
        ticks(32);

        // Asynchronous reset while in alarm.
        do_enter(2'b01);
        ticks(32);
        do_enter(2'b01);
        chk("alarm_again", 1'b0, 1'b0, 1'b1, 4'd3);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_alarm", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_enter(2'b10);
        chk("after_rst_alarm_open", 1'b1, 1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
